// File: rtl/fp_pkg.sv
// Shared types and helpers for the FP execute stage: op encoding, the
// result record carried through the output FIFO, and IEEE-754 repacking.
package fp_pkg;

    typedef enum logic [1:0] {
        FP_ADD = 2'b00,
        FP_SUB = 2'b01,
        FP_MUL = 2'b10,
        FP_CMP = 2'b11
    } fp_op_e;

    // Tag field is sized for the widest supported TAG_W; narrower tags are zero-extended.
    localparam int unsigned FP_TAG_MAX = 16;

    typedef struct packed {
        logic [31:0]           res;
        logic                  gt;
        logic [FP_TAG_MAX-1:0] tag;
    } fp_res_t;

    localparam int unsigned FP_PIPE_LAT = 3;

    // Round-to-nearest-even on a normalised 24-bit mantissa, then pack with
    // overflow to infinity and underflow flushed to signed zero.
    function automatic logic [31:0] fp_round_pack(
        input logic              sign,
        input logic signed [9:0] exp,
        input logic [23:0]       mant,
        input logic              grd,
        input logic              rnd,
        input logic              stk
    );
        logic [24:0]       m;
        logic signed [9:0] e;
        m = {1'b0, mant} + {24'b0, grd & (rnd | stk | mant[0])};
        e = exp;
        if (m[24]) begin
            m = m >> 1;
            e = e + 10'sd1;
        end
        if (e >= 10'sd255) return {sign, 8'hFF, 23'b0};
        if (e <= 10'sd0)   return {sign, 31'b0};
        return {sign, e[7:0], m[22:0]};
    endfunction

endpackage

// File: rtl/fp_alu.sv
// Combinational single-precision add/sub/mul/compare. Denormal operands and
// results are flushed to zero for arithmetic; compare uses the raw encodings.
module fp_alu
    import fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  fp_op_e      op,
    output logic [31:0] res,
    output logic        gt
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    always_comb begin
        sa     = a[31];
        sb     = b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        a_inf  = (ea == 8'hFF) && (a[22:0] == '0);
        b_inf  = (eb == 8'hFF) && (b[22:0] == '0);
        a_nan  = (ea == 8'hFF) && (a[22:0] != '0);
        b_nan  = (eb == 8'hFF) && (b[22:0] != '0);
        ma     = a_zero ? '0 : {1'b1, a[22:0]};
        mb     = b_zero ? '0 : {1'b1, b[22:0]};
    end

    logic              sb_eff, s_big, s_sml;
    logic [7:0]        e_big, e_sml, d8;
    logic [23:0]       m_big, m_sml;
    logic [27:0]       x_big, x_sml, x_sum, lost_mask;
    logic [4:0]        lz;
    logic signed [9:0] e_sum;
    logic [31:0]       add_res;

    always_comb begin
        sb_eff = sb ^ (op == FP_SUB);
        if ({ea, ma} >= {eb, mb}) begin
            s_big = sa;     e_big = ea; m_big = ma;
            s_sml = sb_eff; e_sml = eb; m_sml = mb;
        end else begin
            s_big = sb_eff; e_big = eb; m_big = mb;
            s_sml = sa;     e_sml = ea; m_sml = ma;
        end
        d8        = e_big - e_sml;
        x_big     = {1'b0, m_big, 3'b000};
        x_sml     = {1'b0, m_sml, 3'b000};
        lost_mask = '0;
        lz        = '0;
        // Smaller operand is aligned into guard/round bits, with everything below folded into sticky.
        if (d8 >= 8'd27) begin
            x_sml = {27'b0, |m_sml};
        end else begin
            lost_mask = ~({28{1'b1}} << d8);
            x_sml     = (x_sml >> d8) | {27'b0, |(x_sml & lost_mask)};
        end
        e_sum = $signed({2'b00, e_big});
        if (s_big == s_sml) begin
            x_sum = x_big + x_sml;
            if (x_sum[27]) begin
                x_sum = {1'b0, x_sum[27:1]} | {27'b0, x_sum[0]};
                e_sum = e_sum + 10'sd1;
            end
        end else begin
            x_sum = x_big - x_sml;
            for (int unsigned i = 0; i < 27; i++) begin
                if (x_sum[i]) lz = 5'(26 - i);
            end
            x_sum = x_sum << lz;
            e_sum = e_sum - $signed({5'b0, lz});
        end

        if (a_nan || b_nan)
            add_res = QNAN;
        else if (a_inf && b_inf)
            add_res = (sa != sb_eff) ? QNAN : {sa, 8'hFF, 23'b0};
        else if (a_inf)
            add_res = {sa, 8'hFF, 23'b0};
        else if (b_inf)
            add_res = {sb_eff, 8'hFF, 23'b0};
        else if (x_sum == '0)
            add_res = {s_big & s_sml, 31'b0};
        else
            add_res = fp_round_pack(s_big, e_sum, x_sum[26:3], x_sum[2], x_sum[1], x_sum[0]);
    end

    logic [47:0]       prod;
    logic signed [9:0] e_mul;
    logic              s_mul;
    logic [31:0]       mul_res;

    always_comb begin
        prod  = 48'(ma) * 48'(mb);
        s_mul = sa ^ sb;
        e_mul = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        if (a_nan || b_nan)
            mul_res = QNAN;
        else if ((a_inf && b_zero) || (b_inf && a_zero))
            mul_res = QNAN;
        else if (a_inf || b_inf)
            mul_res = {s_mul, 8'hFF, 23'b0};
        else if (a_zero || b_zero)
            mul_res = {s_mul, 31'b0};
        else if (prod[47])
            mul_res = fp_round_pack(s_mul, e_mul + 10'sd1, prod[47:24], prod[23], prod[22], |prod[21:0]);
        else
            mul_res = fp_round_pack(s_mul, e_mul, prod[46:23], prod[22], prod[21], |prod[20:0]);
    end

    logic cmp_gt;

    always_comb begin
        cmp_gt = 1'b0;
        if (!a_nan && !b_nan && !((a[30:0] == '0) && (b[30:0] == '0))) begin
            case ({sa, sb})
                2'b00:   cmp_gt = a[30:0] > b[30:0];
                2'b01:   cmp_gt = 1'b1;
                2'b10:   cmp_gt = 1'b0;
                default: cmp_gt = a[30:0] < b[30:0];
            endcase
        end
    end

    always_comb begin
        res = add_res;
        gt  = 1'b0;
        case (op)
            FP_MUL: res = mul_res;
            FP_CMP: begin
                res = b;
                gt  = cmp_gt;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fp_res_fifo.sv
// Registered-storage FIFO of fp_res_t; head is read directly from storage.
// Flush resets pointers and count and takes priority over push/pop.
module fp_res_fifo
    import fp_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  fp_res_t          din,
    output fp_res_t          dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fp_res_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign dout   = mem[rd_ptr];
    assign do_pop = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_alu_pipe.sv
// Two-register execute stage around fp_alu feeding a result FIFO. Credits
// cover every op in flight, so the pipeline never stalls and the FIFO never overflows.
module fp_alu_pipe
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_res,
    output logic             out_gt,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      op_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    // Holds fifo_count plus the FP_PIPE_LAT-1 pipeline valid bits.
    localparam int unsigned SUM_W = $clog2(DEPTH + FP_PIPE_LAT);

    logic             accept;
    logic             s1_v;
    logic [31:0]      s1_a, s1_b;
    fp_op_e           s1_op;
    logic [TAG_W-1:0] s1_tag;
    logic [31:0]      alu_res;
    logic             alu_gt;
    logic             s2_v;
    fp_res_t          s2_q;
    fp_res_t          head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    logic [SUM_W-1:0] credits_used;
    logic [31:0]      op_cnt;

    always_comb begin
        credits_used = SUM_W'(fifo_count) + SUM_W'(s1_v) + SUM_W'(s2_v);
        in_ready     = credits_used < SUM_W'(DEPTH);
        accept       = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_op  <= FP_ADD;
            s1_tag <= '0;
        end else begin
            s1_v <= accept && !flush;
            if (accept) begin
                s1_a   <= in_a;
                s1_b   <= in_b;
                s1_op  <= fp_op_e'(in_op);
                s1_tag <= in_tag;
            end
        end
    end

    fp_alu u_alu (
        .a   (s1_a),
        .b   (s1_b),
        .op  (s1_op),
        .res (alu_res),
        .gt  (alu_gt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v <= 1'b0;
            s2_q <= '0;
        end else begin
            s2_v <= s1_v && !flush;
            if (s1_v) begin
                s2_q.res <= alu_res;
                s2_q.gt  <= alu_gt;
                s2_q.tag <= FP_TAG_MAX'(s1_tag);
            end
        end
    end

    fp_res_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (s2_v),
        .pop   (out_valid && out_ready),
        .din   (s2_q),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_res   = head.res;
    assign out_gt    = head.gt;
    assign out_tag   = head.tag[TAG_W-1:0];

    generate
        if (TAG_W < FP_TAG_MAX) begin : g_tag_pad
            logic unused_tag_hi;
            assign unused_tag_hi = ^head.tag[FP_TAG_MAX-1:TAG_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) op_cnt <= '0;
        else        op_cnt <= op_cnt + 32'(accept);
    end

    assign op_count = op_cnt;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(s2_v && fifo_full))
        else $error("fp_alu_pipe: result FIFO written while full");

endmodule

// File: tb/tb_fp_alu_pipe.sv
// Bench for fp_alu_pipe: vector table through a scoreboard, plus sequences
// for throughput, backpressure, flush, async reset and op_count wrap.
module tb_fp_alu_pipe;
    import fp_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned NVEC  = 15;

    logic             clk = 1'b0;
    logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_gt;
    logic [31:0]      in_a, in_b, out_res, op_count;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag, out_tag;

    always #5 clk = ~clk;

    fp_alu_pipe #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_gt    (out_gt),
        .out_tag   (out_tag),
        .op_count  (op_count)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] res;
        logic        gt;
    } vec_t;

    typedef struct {
        logic [31:0]      res;
        logic             gt;
        logic [TAG_W-1:0] tag;
    } exp_t;

    vec_t        vecs [NVEC];
    exp_t        sb_q [$];
    exp_t        mon_e;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] acc_model = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Pops are judged half a cycle before the edge that performs them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                sb_q.delete();
            end else if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL result_unexpected: got tag %0d res %h, expected no result", out_tag, out_res);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (out_res !== mon_e.res || out_gt !== mon_e.gt || out_tag !== mon_e.tag) begin
                        errors++;
                        $display("FAIL result tag %0d: got res %h gt %b tag %0d expected res %h gt %b tag %0d",
                                 mon_e.tag, out_res, out_gt, out_tag, mon_e.res, mon_e.gt, mon_e.tag);
                    end
                end
            end
        end
    end

    task automatic try_send(input vec_t v, input logic [TAG_W-1:0] tag, output bit took);
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        in_op    = v.op;
        in_tag   = tag;
        @(negedge clk);
        took = in_ready;
        if (took) begin
            acc_model = acc_model + 32'd1;
            if (!flush) sb_q.push_back('{res: v.res, gt: v.gt, tag: tag});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input vec_t v, input logic [TAG_W-1:0] tag);
        bit took = 1'b0;
        for (int i = 0; i < 20 && !took; i++) try_send(v, tag, took);
        if (!took) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout tag %0d: got in_ready 0 for 20 cycles, expected an accept", tag);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit          took;
        int          n;
        int unsigned stalls, idx;

        vecs[0]  = '{32'h3FC00000, 32'h40100000, 2'b00, 32'h40700000, 1'b0};
        vecs[1]  = '{32'h40400000, 32'h40000000, 2'b10, 32'h40C00000, 1'b0};
        vecs[2]  = '{32'h40400000, 32'h40000000, 2'b01, 32'h3F800000, 1'b0};
        vecs[3]  = '{32'h40000000, 32'h3F800000, 2'b11, 32'h3F800000, 1'b1};
        vecs[4]  = '{32'h3F800000, 32'h40000000, 2'b11, 32'h40000000, 1'b0};
        vecs[5]  = '{32'h3F800000, 32'h3F800000, 2'b00, 32'h40000000, 1'b0};
        vecs[6]  = '{32'h3F800000, 32'h3F800000, 2'b01, 32'h00000000, 1'b0};
        vecs[7]  = '{32'hC0000000, 32'h40400000, 2'b10, 32'hC0C00000, 1'b0};
        vecs[8]  = '{32'h3F800000, 32'hC0400000, 2'b00, 32'hC0000000, 1'b0};
        vecs[9]  = '{32'hBF800000, 32'hC0000000, 2'b11, 32'hC0000000, 1'b1};
        vecs[10] = '{32'h3F800001, 32'h33800000, 2'b00, 32'h3F800002, 1'b0};
        vecs[11] = '{32'h7F000000, 32'h40000000, 2'b10, 32'h7F800000, 1'b0};
        vecs[12] = '{32'h40000000, 32'h40400000, 2'b01, 32'hBF800000, 1'b0};
        vecs[13] = '{32'h3F000000, 32'h3F000000, 2'b10, 32'h3E800000, 1'b0};
        vecs[14] = '{32'h40400000, 32'h40400000, 2'b11, 32'h40400000, 1'b0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
        #12 rst_n = 1'b1;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_res", out_res, 0);
        check("reset_out_gt", out_gt, 0);
        check("reset_out_tag", out_tag, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_op_count", op_count, 0);
        @(posedge clk);
        #1;

        // Single ops: value via scoreboard, latency from accept edge to out_valid.
        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i], TAG_W'(i));
            n = 0;
            while (!out_valid && n < 8) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("latency", n, FP_PIPE_LAT - 1);
            wait_drain("single_drain");
        end
        check("op_count_table", op_count, acc_model);

        // Back-to-back ops: no stalls and one result per cycle.
        stalls = 0;
        for (int k = 0; k < 20; k++) begin
            try_send(vecs[k % NVEC], TAG_W'(k), took);
            if (!took) stalls++;
        end
        check("throughput_stalls", stalls, 0);
        repeat (FP_PIPE_LAT) @(posedge clk);
        #1;
        check("throughput_pending", sb_q.size(), 0);
        wait_drain("throughput_drain");

        // Backpressure: only DEPTH ops get in while the output is stalled.
        out_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 10; k++) begin
            try_send(vecs[idx], TAG_W'(20 + idx), took);
            if (took) idx++;
        end
        check("bp_accepted", idx, DEPTH);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_drain("bp_drain");
        check("bp_in_ready_after", in_ready, 1);

        // Flush with one op in S1, one in S2 and two in the FIFO.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            try_send(vecs[k + 5], TAG_W'(k + 1), took);
            if (!took) check("flush_setup_accept", 0, 1);
        end
        check("flush_setup_valid", out_valid, 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        check("flush_no_leak", out_valid, 0);
        out_ready = 1'b1;
        send(vecs[7], TAG_W'(7));
        wait_drain("flush_recover");
        check("flush_op_count", op_count, acc_model);

        // Accept coinciding with flush: counted but discarded.
        flush = 1'b1;
        try_send(vecs[0], TAG_W'(9), took);
        flush = 1'b0;
        check("flush_cycle_accept", took, 1);
        repeat (4) @(posedge clk);
        #1;
        check("flush_cycle_dropped", out_valid, 0);
        check("flush_cycle_op_count", op_count, acc_model);

        // Asynchronous reset between edges with ops in flight.
        out_ready = 1'b0;
        send(vecs[1], TAG_W'(3));
        send(vecs[2], TAG_W'(4));
        #2 rst_n = 1'b0;
        #1;
        check("areset_out_valid", out_valid, 0);
        check("areset_op_count", op_count, 0);
        sb_q.delete();
        acc_model = '0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("areset_in_ready", in_ready, 1);
        check("areset_out_valid_after", out_valid, 0);
        check("areset_op_count_after", op_count, 0);
        out_ready = 1'b1;
        send(vecs[13], TAG_W'(13));
        wait_drain("areset_recover");
        check("areset_op_count_one", op_count, 1);

        // op_count wraps from all-ones to zero.
        force dut.op_cnt = 32'hFFFF_FFFF;
        #1 release dut.op_cnt;
        check("wrap_preset", op_count, 32'hFFFF_FFFF);
        acc_model = 32'hFFFF_FFFF;
        send(vecs[3], TAG_W'(30));
        check("wrap_op_count", op_count, acc_model);
        check("wrap_zero", op_count, 0);
        wait_drain("wrap_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
